// File: rtl/cpu_run_ctrl.sv
// Run/step controller between the two board push-buttons and the CPU core.
// Each button is synchronized and debounced into a one-cycle press event.
// The press events drive a four-mode sequencer (idle, single-step, free-run,
// halted) that produces the CPU clock enable.
// The block also latches the CPU output value for the display and counts
// enabled cycles.

module cpu_run_ctrl_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic but_i,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic             deb_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive samples that disagree with the accepted level; flip on the last one
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            deb_d = ~deb_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Synchronizer chain, debounce state and previous level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= but_i;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    // Press is a rising edge of the accepted level; it depends on registers only
    assign press_o = deb_q & ~deb_prev_q;

endmodule

module cpu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_CYCLES     = 1,
    parameter int DATA_W          = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              but1,
    input  logic              but2,
    input  logic              cpu_halted,
    input  logic [DATA_W-1:0] value_in,
    output logic              cpu_en,
    output logic [DATA_W-1:0] value,
    output logic [1:0]        state,
    output logic [15:0]       cycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_STEP = 2'b01,
        ST_RUN  = 2'b10,
        ST_HALT = 2'b11
    } state_e;

    localparam int STEP_W = $clog2(STEP_CYCLES + 1);
    localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_CYCLES);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    logic              press1_s;
    logic              press2_s;
    state_e            state_q;
    state_e            state_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic              cpu_en_q;
    logic              cpu_en_d;
    logic [DATA_W-1:0] value_q;
    logic [DATA_W-1:0] value_d;
    logic [15:0]       cycles_q;
    logic [15:0]       cycles_d;

    cpu_run_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .but_i   (but1),
        .press_o (press1_s)
    );

    cpu_run_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .but_i   (but2),
        .press_o (press2_s)
    );

    // Mode sequencing; the enable is derived from the next mode so it is a registered Moore output
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE: begin
                if (press1_s) begin
                    state_d = ST_RUN;
                end else if (press2_s && !cpu_halted) begin
                    state_d = ST_STEP;
                    step_d  = STEP_LOAD;
                end else if (press2_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                // Presses and halt are ignored until the step has issued all its cycles
                if (step_q <= STEP_ONE) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end else begin
                    step_d  = step_q - STEP_ONE;
                end
            end
            ST_RUN: begin
                if (cpu_halted) begin
                    state_d = ST_HALT;
                end else if (press1_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (press1_s || press2_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
        cpu_en_d = (state_d == ST_STEP) || (state_d == ST_RUN);
    end

    // Capture the CPU value and count cycles for every cycle the CPU was enabled
    always_comb begin
        if (cpu_en_q) begin
            value_d  = value_in;
            cycles_d = cycles_q + 16'd1;
        end else begin
            value_d  = value_q;
            cycles_d = cycles_q;
        end
    end

    // State, enable, display value and cycle counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            cpu_en_q <= 1'b0;
            value_q  <= '0;
            cycles_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cpu_en_q <= cpu_en_d;
            value_q  <= value_d;
            cycles_q <= cycles_d;
        end
    end

    assign cpu_en = cpu_en_q;
    assign value  = value_q;
    assign state  = state_q;
    assign cycles = cycles_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a reference model checked against the outputs every cycle,
// directed scenarios with literal expectations, and a randomized button/halt phase.
`timescale 1ns/1ps

module tb_cpu_run_ctrl;

    localparam int D = 4;
    localparam int S = 3;

    localparam logic [1:0] M_IDLE = 2'b00;
    localparam logic [1:0] M_STEP = 2'b01;
    localparam logic [1:0] M_RUN  = 2'b10;
    localparam logic [1:0] M_HALT = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        but1 = 1'b0;
    logic        but2 = 1'b0;
    logic        cpu_halted = 1'b0;
    logic [7:0]  value_in = 8'h00;
    logic        cpu_en;
    logic [7:0]  value;
    logic [1:0]  state;
    logic [15:0] cycles;

    int tests = 0;
    int fails = 0;

    cpu_run_ctrl #(.DEBOUNCE_CYCLES(D), .STEP_CYCLES(S), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .but1       (but1),
        .but2       (but2),
        .cpu_halted (cpu_halted),
        .value_in   (value_in),
        .cpu_en     (cpu_en),
        .value      (value),
        .state      (state),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples per edge; a level is accepted once the D synced
    // samples (raw delayed by two edges) all disagree with the current accepted level.
    logic [D+1:0] h1 = '0;
    logic [D+1:0] h2 = '0;
    logic         deb1 = 1'b0;
    logic         deb2 = 1'b0;
    logic         p1 = 1'b0;
    logic         p2 = 1'b0;
    logic [1:0]   m_mode = M_IDLE;
    int           m_rem = 0;
    logic [15:0]  m_cycles = 16'd0;
    logic [7:0]   m_value = 8'h00;
    logic         m_en;

    assign m_en = (m_mode == M_STEP) || (m_mode == M_RUN);

    always @(posedge clk) begin
        if (!rst_n) begin
            h1 = '0; h2 = '0; deb1 = 1'b0; deb2 = 1'b0; p1 = 1'b0; p2 = 1'b0;
            m_mode = M_IDLE; m_rem = 0; m_cycles = 16'd0; m_value = 8'h00;
        end else begin
            if (m_en) begin
                m_cycles = m_cycles + 16'd1;
                m_value  = value_in;
            end
            case (m_mode)
                M_IDLE: begin
                    if (p1) m_mode = M_RUN;
                    else if (p2 && !cpu_halted) begin m_mode = M_STEP; m_rem = S; end
                    else if (p2) m_mode = M_HALT;
                end
                M_STEP: begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_mode = M_IDLE;
                end
                M_RUN: begin
                    if (cpu_halted) m_mode = M_HALT;
                    else if (p1) m_mode = M_IDLE;
                end
                default: begin
                    if (p1 || p2) m_mode = M_IDLE;
                end
            endcase
            h1 = {h1[D:0], but1};
            h2 = {h2[D:0], but2};
            p1 = 1'b0;
            p2 = 1'b0;
            if (h1[D+1:2] == {D{~deb1}}) begin deb1 = ~deb1; p1 = deb1; end
            if (h2[D+1:2] == {D{~deb2}}) begin deb2 = ~deb2; p2 = deb2; end
        end
        #1;
        tests++;
        if (state !== m_mode || cpu_en !== m_en || value !== m_value || cycles !== m_cycles) begin
            fails++;
            $display("FAIL cycle_cmp t=%0t got state=%0d en=%0b value=%h cycles=%0d, expected state=%0d en=%0b value=%h cycles=%0d",
                     $time, state, cpu_en, value, cycles, m_mode, m_en, m_value, m_cycles);
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int which, input int hold);
        if (which == 1) but1 = 1'b1; else but2 = 1'b1;
        idle(hold);
        if (which == 1) but1 = 1'b0; else but2 = 1'b0;
    endtask

    task automatic wait_mode(input logic [1:0] m, input int budget);
        int n;
        n = 0;
        while (m_mode != m && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (m_mode != m) begin
            tests++;
            fails++;
            $display("FAIL wait_mode timeout got mode %0d expected %0d", m_mode, m);
        end
    endtask

    logic [15:0] c_save;

    initial begin
        // Reset and idle
        idle(3);
        rst_n = 1'b1;
        idle(50);
        lit("reset_state", 32'(state), 32'd0);
        lit("reset_en", 32'(cpu_en), 32'd0);
        lit("reset_value", 32'(value), 32'd0);
        lit("reset_cycles", 32'(cycles), 32'd0);

        // Short bounces must be rejected, a steady press gives one step
        value_in = 8'h5A;
        press(2, 3); idle(2); press(2, 3); idle(10);
        lit("bounce_state", 32'(state), 32'd0);
        lit("bounce_cycles", 32'(cycles), 32'd0);
        press(2, 10);
        idle(20);
        lit("step_cycles", 32'(cycles), 32'd3);
        lit("step_value", 32'(value), 32'h5A);
        lit("step_state", 32'(state), 32'd0);

        // Run / stop with step button ignored while running
        press(1, 8);
        for (int i = 0; i < 20; i++) begin
            value_in = 8'($urandom);
            @(negedge clk);
        end
        press(2, 8);
        idle(5);
        lit("run_ignores_b2", 32'(state), 32'h2);
        press(1, 8);
        idle(10);
        lit("run_stop_state", 32'(state), 32'd0);

        // Halt from run, acknowledge, then step request while halted
        press(1, 8);
        idle(10);
        cpu_halted = 1'b1;
        idle(2);
        lit("halt_state", 32'(state), 32'h3);
        lit("halt_en", 32'(cpu_en), 32'd0);
        press(2, 8);
        idle(10);
        lit("halt_ack_state", 32'(state), 32'd0);
        c_save = m_cycles;
        press(2, 8);
        idle(10);
        lit("halted_step_state", 32'(state), 32'h3);
        lit("halted_step_cycles", 32'(cycles), 32'(c_save));
        cpu_halted = 1'b0;
        press(1, 8);
        idle(10);

        // Simultaneous presses in idle: run wins
        but1 = 1'b1; but2 = 1'b1;
        idle(8);
        but1 = 1'b0; but2 = 1'b0;
        idle(10);
        lit("simul_state", 32'(state), 32'h2);
        press(1, 8);
        idle(10);

        // Randomized buttons, halt and values
        for (int seg = 0; seg < 400; seg++) begin
            but1 = ($urandom_range(0, 3) == 0);
            but2 = ($urandom_range(0, 3) == 0);
            cpu_halted = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(1, 10)) begin
                value_in = 8'($urandom);
                @(negedge clk);
            end
        end
        but1 = 1'b0; but2 = 1'b0; cpu_halted = 1'b0;

        // Counter wrap after 65536 enabled cycles from reset
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        but1 = 1'b1;
        wait_mode(M_RUN, 50);
        but1 = 1'b0;
        idle(65536);
        lit("wrap_cycles", 32'(cycles), 32'd0);
        lit("wrap_state", 32'(state), 32'h2);

        // Asynchronous reset mid-run with the run button held through it
        but1 = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        lit("async_rst_en", 32'(cpu_en), 32'd0);
        lit("async_rst_state", 32'(state), 32'd0);
        idle(2);
        rst_n = 1'b1;
        wait_mode(M_RUN, 50);
        idle(1);
        lit("rearm_state", 32'(state), 32'h2);
        but1 = 1'b0;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
